// File: rtl/control_lecturas_mem_externa_2d.sv
// control_lecturas_mem_externa_2d: fetches an ancho_img x alto_img window from external memory, one read at a time, gated by buffer space
// Ports: clk, reset (sync, active-high); iniciar starts a transfer from REPOSO; buf_space_available gates each read;
//   direccion_mem_inicio_img / ancho_img / alto_img / paso_linea are latched on start; lectura_mem_completada acks the read;
//   read_mem / address_mem form the memory request; save_mem_data pulses per returned word; ocupado is high outside REPOSO;
//   terminado pulses once after the last read; error_timeout is the sticky timeout flag.
// Optional feature: define CONTROL_LECTURAS_TIMEOUT_EN to abort a read after TIMEOUT_CICLOS cycles without acknowledge.
module control_lecturas_mem_externa_2d #(
  parameter int ADDR_W = 21,
  parameter int DIM_W = 11,
  parameter int TIMEOUT_CICLOS = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              buf_space_available,
  input  logic [ADDR_W-1:0] direccion_mem_inicio_img,
  input  logic [DIM_W-1:0]  ancho_img,
  input  logic [DIM_W-1:0]  alto_img,
  input  logic [ADDR_W-1:0] paso_linea,
  input  logic              lectura_mem_completada,
  output logic              read_mem,
  output logic [ADDR_W-1:0] address_mem,
  output logic              save_mem_data,
  output logic              ocupado,
  output logic              terminado,
  output logic              error_timeout
);
  localparam logic [1:0] REPOSO = 2'd0, ESPERA_BUF = 2'd1, LEER = 2'd2, FIN = 2'd3;
  logic [1:0] estado;
  logic [DIM_W-1:0] ancho_l, alto_l, col, fila;
  logic [ADDR_W-1:0] paso_l, dir_fila, sig_fila;
  logic ultima_col, ultima_fila;
  assign sig_fila = dir_fila + paso_l;
  assign ultima_col = col == ancho_l - DIM_W'(1);
  assign ultima_fila = fila == alto_l - DIM_W'(1);
`ifdef CONTROL_LECTURAS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1) > 8 ? $clog2(TIMEOUT_CICLOS + 1) : 8;
  logic [TW-1:0] cnt;
`else
  // Feature disabled: the flag can never rise (the comparison is constant false).
  assign error_timeout = TIMEOUT_CICLOS < 0;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      estado <= REPOSO;
      read_mem <= 1'b0;
      address_mem <= '0;
      save_mem_data <= 1'b0;
      ocupado <= 1'b0;
      terminado <= 1'b0;
      ancho_l <= '0;
      alto_l <= '0;
      col <= '0;
      fila <= '0;
      paso_l <= '0;
      dir_fila <= '0;
`ifdef CONTROL_LECTURAS_TIMEOUT_EN
      cnt <= '0;
      error_timeout <= 1'b0;
`endif
    end else begin
      save_mem_data <= 1'b0;
      terminado <= 1'b0;
      case (estado)
        REPOSO: if (iniciar) begin
          ancho_l <= ancho_img;
          alto_l <= alto_img;
          paso_l <= paso_linea;
          col <= '0;
          fila <= '0;
          dir_fila <= direccion_mem_inicio_img;
          address_mem <= direccion_mem_inicio_img;
          ocupado <= 1'b1;
          estado <= (ancho_img == '0 || alto_img == '0) ? FIN : ESPERA_BUF;
`ifdef CONTROL_LECTURAS_TIMEOUT_EN
          error_timeout <= 1'b0;
`endif
        end
        ESPERA_BUF: if (buf_space_available) begin
          read_mem <= 1'b1;
          estado <= LEER;
`ifdef CONTROL_LECTURAS_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        LEER: if (lectura_mem_completada) begin
          read_mem <= 1'b0;
          save_mem_data <= 1'b1;
          if (!ultima_col) begin
            col <= col + DIM_W'(1);
            address_mem <= address_mem + ADDR_W'(1);
            estado <= ESPERA_BUF;
          end else if (!ultima_fila) begin
            col <= '0;
            fila <= fila + DIM_W'(1);
            dir_fila <= sig_fila;
            address_mem <= sig_fila;
            estado <= ESPERA_BUF;
          end else begin
            estado <= FIN;
          end
        end
`ifdef CONTROL_LECTURAS_TIMEOUT_EN
        else if (cnt == TW'(TIMEOUT_CICLOS - 1)) begin
          read_mem <= 1'b0;
          error_timeout <= 1'b1;
          ocupado <= 1'b0;
          estado <= REPOSO;
        end else begin
          cnt <= cnt + TW'(1);
        end
`endif
        default: begin
          terminado <= 1'b1;
          ocupado <= 1'b0;
          estado <= REPOSO;
        end
      endcase
    end
  end
endmodule
